uio_bus_arbiter: RTL and testbench

Shares the 8-bit bidirectional uio pin bank between up to four internal requesters inside the micro1 design, so that no two agents ever drive the board pins at once. Grants one owner at a time with round-robin fairness, inserts a floated turnaround window on every ownership change, optionally preempts long holders, and returns synchronized pin input data to all requesters. Sits between the requesters and the uio_out/uio_oe/uio_in ports that the board top converts to tristate pins.

---
 rtl/uio_arb_pkg.sv | 25 ++
 rtl/uio_in_sync.sv | 43 ++++
 rtl/uio_bus_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uio_arb_pkg.sv
// -----------------------------------------------------------------------------
// uio_arb_pkg
// Shared definitions for the uio pin-bank arbiter: arbiter state encoding,
// structural widths and the saturating hold-counter helper.
// -----------------------------------------------------------------------------
package uio_arb_pkg;

    localparam int MAX_REQ = 4;   // largest supported requester count
    localparam int PIN_W   = 8;   // width of the uio pin bank
    localparam int HOLD_W  = 8;   // hold counter width (saturates at 255)
    localparam int TURN_W  = 4;   // turnaround counter width (up to 15 cycles)

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } arb_state_e;

    // Increment that sticks at all-ones so a long sole holder never wraps
    // back into the preemption window.
    function automatic logic [HOLD_W-1:0] hold_sat_inc(input logic [HOLD_W-1:0] v);
        return (v == {HOLD_W{1'b1}}) ? v : v + HOLD_W'(1);
    endfunction

endpackage

// File: rtl/uio_in_sync.sv
// -----------------------------------------------------------------------------
// uio_in_sync
// Two-flop synchronizer for the asynchronous uio pin inputs.
// Ports:
//   clk    - sampling clock
//   rst_n  - asynchronous active-low reset, clears both stages to 0
//   d      - raw pin input
//   q      - synchronized value, d delayed by two clock edges
// -----------------------------------------------------------------------------
module uio_in_sync
    import uio_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIN_W-1:0] d,
    output logic [PIN_W-1:0] q
);

    logic [PIN_W-1:0] meta_d;
    logic [PIN_W-1:0] meta_q;
    logic [PIN_W-1:0] sync_d;
    logic [PIN_W-1:0] sync_q;

    // Next-state for the two synchronizer stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages; first stage may go metastable, second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// uio_bus_arbiter
// Shares the 8-bit bidirectional uio pin bank between NUM_REQ internal
// requesters. One owner at a time, round-robin fairness, a floated turnaround
// window on each ownership change and optional preemption of long holders.
// Ports:
//   clk_100mhz   - sole clock
//   rst_n        - asynchronous active-low reset
//   req          - level request per requester
//   gnt          - registered one-hot grant
//   wdata / woe  - per-requester pin data / per-bit enable, requester i at
//                  [8i+7:8i]
//   owner        - index of current owner (meaningful while owner_valid)
//   owner_valid  - high while a requester owns the pins
//   rdata        - uio_in after a 2-flop synchronizer
//   uio_in       - pin input
//   uio_out      - registered pin data
//   uio_oe       - registered pin output enable
// -----------------------------------------------------------------------------
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 64
) (
    input  logic                     clk_100mhz,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       gnt,
    input  logic [PIN_W*NUM_REQ-1:0] wdata,
    input  logic [PIN_W*NUM_REQ-1:0] woe,
    output logic [1:0]               owner,
    output logic                     owner_valid,
    output logic [PIN_W-1:0]         rdata,
    input  logic [PIN_W-1:0]         uio_in,
    output logic [PIN_W-1:0]         uio_out,
    output logic [PIN_W-1:0]         uio_oe
);

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [TURN_W-1:0] TURN_LOAD  = TURN_W'(TURN_CYCLES - 1);
    localparam logic [1:0]        LAST_IDX   = 2'(NUM_REQ - 1);
    localparam logic              PREEMPT_EN = (MAX_HOLD != 0) ? 1'b1 : 1'b0;

    arb_state_e           state_d, state_q;
    logic [NUM_REQ-1:0]   gnt_d, gnt_q;
    logic [1:0]           owner_d, owner_q;
    logic                 owner_valid_d, owner_valid_q;
    logic [PIN_W-1:0]     uio_out_d, uio_out_q;
    logic [PIN_W-1:0]     uio_oe_d, uio_oe_q;
    logic [1:0]           rr_d, rr_q;
    logic [HOLD_W-1:0]    hold_cnt_d, hold_cnt_q;
    logic [TURN_W-1:0]    turn_cnt_d, turn_cnt_q;

    logic [NUM_REQ-1:0]   upper_mask_s;
    logic [NUM_REQ-1:0]   upper_req_s;
    logic [1:0]           upper_win_s;
    logic [1:0]           any_win_s;
    logic [1:0]           winner_s;
    logic                 any_req_s;
    logic [NUM_REQ-1:0]   win_gnt_s;
    logic [1:0]           win_rr_s;

    logic [PIN_W-1:0]     sel_wdata_s;
    logic [PIN_W-1:0]     sel_woe_s;
    logic                 sel_req_s;
    logic                 others_s;
    logic                 release_s;

    // Round-robin pick: lowest request at or above rr, else lowest overall
    // (the wrap-around case). Loops run high-to-low so the last hit wins.
    always_comb begin
        upper_mask_s = '0;
        upper_win_s  = 2'd0;
        any_win_s    = 2'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            upper_mask_s[i] = (2'(i) >= rr_q) ? 1'b1 : 1'b0;
        end
        upper_req_s = req & upper_mask_s;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            upper_win_s = upper_req_s[i] ? 2'(i) : upper_win_s;
            any_win_s   = req[i] ? 2'(i) : any_win_s;
        end
        winner_s  = (|upper_req_s) ? upper_win_s : any_win_s;
        any_req_s = |req;
        win_gnt_s = NUM_REQ'(1) << winner_s;
        win_rr_s  = (winner_s == LAST_IDX) ? 2'd0 : winner_s + 2'd1;
    end

    // Select the current owner's pin data, enables and request level.
    always_comb begin
        sel_wdata_s = '0;
        sel_woe_s   = '0;
        sel_req_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_wdata_s = (owner_q == 2'(i)) ? wdata[PIN_W*i +: PIN_W] : sel_wdata_s;
            sel_woe_s   = (owner_q == 2'(i)) ? woe[PIN_W*i +: PIN_W]   : sel_woe_s;
            sel_req_s   = (owner_q == 2'(i)) ? req[i]                  : sel_req_s;
        end
        // gnt_q is the owner's one-hot, so masking it leaves only waiters.
        others_s  = |(req & ~gnt_q);
        release_s = !sel_req_s ||
                    (PREEMPT_EN && (hold_cnt_q == HOLD_LAST) && others_s);
    end

    // Arbiter FSM and pin register next-state.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        uio_out_d     = uio_out_q;
        uio_oe_d      = uio_oe_q;
        rr_d          = rr_q;
        hold_cnt_d    = hold_cnt_q;
        turn_cnt_d    = turn_cnt_q;
        case (state_q)
            IDLE: begin
                uio_oe_d = '0;
                if (any_req_s) begin
                    state_d       = OWN;
                    gnt_d         = win_gnt_s;
                    owner_d       = winner_s;
                    owner_valid_d = 1'b1;
                    rr_d          = win_rr_s;
                    hold_cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            OWN: begin
                if (release_s) begin
                    // Float the pins on the release edge; uio_out keeps its
                    // last value so the bus does not glitch on re-enable.
                    state_d       = TURN;
                    gnt_d         = '0;
                    owner_valid_d = 1'b0;
                    uio_oe_d      = '0;
                    turn_cnt_d    = TURN_LOAD;
                end else begin
                    uio_out_d  = sel_wdata_s;
                    uio_oe_d   = sel_woe_s;
                    hold_cnt_d = hold_sat_inc(hold_cnt_q);
                end
            end
            TURN: begin
                uio_oe_d = '0;
                if (turn_cnt_q != TURN_W'(0)) begin
                    turn_cnt_d = turn_cnt_q - TURN_W'(1);
                end else if (any_req_s) begin
                    state_d       = OWN;
                    gnt_d         = win_gnt_s;
                    owner_d       = winner_s;
                    owner_valid_d = 1'b1;
                    rr_d          = win_rr_s;
                    hold_cnt_d    = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d       = IDLE;
                gnt_d         = '0;
                owner_valid_d = 1'b0;
                uio_oe_d      = '0;
            end
        endcase
    end

    // Arbiter state, grant and pin registers.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            owner_q       <= 2'd0;
            owner_valid_q <= 1'b0;
            uio_out_q     <= '0;
            uio_oe_q      <= '0;
            rr_q          <= 2'd0;
            hold_cnt_q    <= '0;
            turn_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            uio_out_q     <= uio_out_d;
            uio_oe_q      <= uio_oe_d;
            rr_q          <= rr_d;
            hold_cnt_q    <= hold_cnt_d;
            turn_cnt_q    <= turn_cnt_d;
        end
    end

    uio_in_sync u_in_sync (
        .clk   (clk_100mhz),
        .rst_n (rst_n),
        .d     (uio_in),
        .q     (rdata)
    );

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign owner_valid = owner_valid_q;
    assign uio_out     = uio_out_q;
    assign uio_oe      = uio_oe_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uio_bus_arbiter
// Drives two arbiter instances (2 requesters / turn 2 / hold 4, and
// 4 requesters / turn 1 / hold 64) against a behavioural ownership model.
// -----------------------------------------------------------------------------
module tb_uio_bus_arbiter;

    localparam int A_N = 2, A_TURN = 2, A_HOLD = 4;
    localparam int B_N = 4, B_TURN = 1, B_HOLD = 64;

    logic        clk_100mhz = 1'b0;
    logic        rst_n;
    logic [7:0]  uio_in;

    logic [1:0]  req_a, gnt_a, owner_a;
    logic [15:0] wdata_a, woe_a;
    logic        owner_valid_a;
    logic [7:0]  rdata_a, uio_out_a, uio_oe_a;

    logic [3:0]  req_b, gnt_b;
    logic [1:0]  owner_b;
    logic [31:0] wdata_b, woe_b;
    logic        owner_valid_b;
    logic [7:0]  rdata_b, uio_out_b, uio_oe_b;

    always #5 clk_100mhz = ~clk_100mhz;

    uio_bus_arbiter #(.NUM_REQ(A_N), .TURN_CYCLES(A_TURN), .MAX_HOLD(A_HOLD)) dut_a (
        .clk_100mhz(clk_100mhz), .rst_n(rst_n), .req(req_a), .gnt(gnt_a),
        .wdata(wdata_a), .woe(woe_a), .owner(owner_a), .owner_valid(owner_valid_a),
        .rdata(rdata_a), .uio_in(uio_in), .uio_out(uio_out_a), .uio_oe(uio_oe_a));

    uio_bus_arbiter #(.NUM_REQ(B_N), .TURN_CYCLES(B_TURN), .MAX_HOLD(B_HOLD)) dut_b (
        .clk_100mhz(clk_100mhz), .rst_n(rst_n), .req(req_b), .gnt(gnt_b),
        .wdata(wdata_b), .woe(woe_b), .owner(owner_b), .owner_valid(owner_valid_b),
        .rdata(rdata_b), .uio_in(uio_in), .uio_out(uio_out_b), .uio_oe(uio_oe_b));

    int n_cmp = 0;
    int n_err = 0;

    // Model: who owns (-1 = nobody), how many edges until arbitration is
    // allowed again, the round-robin start point and the pin levels.
    int         m_own  [2];
    int         m_rr   [2];
    int         m_hold [2];
    int         m_gap  [2];
    logic [7:0] m_out  [2];
    logic [7:0] m_oe   [2];
    logic [7:0] rd_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_own[i] = -1; m_rr[i] = 0; m_hold[i] = 0; m_gap[i] = 0;
            m_out[i] = 8'h00; m_oe[i] = 8'h00;
        end
        rd_hist = {};
        rd_hist.push_back(8'h00);
    endtask

    task automatic model_step(input int i, input int n, input int turn, input int maxh,
                              input logic [3:0] r, input logic [31:0] wd, input logic [31:0] we);
        logic [31:0] t;
        logic [3:0]  others;
        if (m_own[i] < 0) begin
            if (m_gap[i] > 0) begin
                m_gap[i]--;
            end else begin
                for (int k = 0; k < n; k++) begin
                    int c;
                    c = (m_rr[i] + k) % n;
                    if (m_own[i] < 0 && r[c]) begin
                        m_own[i]  = c;
                        m_hold[i] = 0;
                        m_rr[i]   = (c + 1) % n;
                    end
                end
            end
        end else begin
            others = r & ~(4'b0001 << m_own[i]);
            if (!r[m_own[i]] || (maxh != 0 && m_hold[i] == maxh - 1 && others != 4'b0000)) begin
                m_own[i] = -1;
                m_gap[i] = turn - 1;
                m_oe[i]  = 8'h00;
            end else begin
                t = wd >> (8 * m_own[i]);
                m_out[i] = t[7:0];
                t = we >> (8 * m_own[i]);
                m_oe[i] = t[7:0];
                if (m_hold[i] < 255) m_hold[i]++;
            end
        end
    endtask

    function automatic logic [31:0] exp_gnt(input int i);
        return (m_own[i] >= 0) ? (32'd1 << m_own[i]) : 32'd0;
    endfunction

    task automatic check_all();
        logic [7:0] rd_exp;
        rd_exp = rd_hist[rd_hist.size() - 2];
        chk("a_gnt", gnt_a, exp_gnt(0));
        chk("a_valid", owner_valid_a, (m_own[0] >= 0) ? 32'd1 : 32'd0);
        chk("a_oe", uio_oe_a, m_oe[0]);
        chk("a_out", uio_out_a, m_out[0]);
        chk("a_onehot", $onehot0(gnt_a), 32'd1);
        if (m_own[0] >= 0) chk("a_owner", owner_a, m_own[0]);
        chk("a_rdata", rdata_a, rd_exp);
        chk("b_gnt", gnt_b, exp_gnt(1));
        chk("b_valid", owner_valid_b, (m_own[1] >= 0) ? 32'd1 : 32'd0);
        chk("b_oe", uio_oe_b, m_oe[1]);
        chk("b_out", uio_out_b, m_out[1]);
        chk("b_onehot", $onehot0(gnt_b), 32'd1);
        if (m_own[1] >= 0) chk("b_owner", owner_b, m_own[1]);
        chk("b_rdata", rdata_b, rd_exp);
    endtask

    // One clock: advance the model with the inputs as they stand, let the
    // DUT take the edge, then compare just after it.
    task automatic tick();
        model_step(0, A_N, A_TURN, A_HOLD, {2'b00, req_a}, {16'h0000, wdata_a}, {16'h0000, woe_a});
        model_step(1, B_N, B_TURN, B_HOLD, req_b, wdata_b, woe_b);
        rd_hist.push_back(uio_in);
        @(posedge clk_100mhz);
        #1;
        check_all();
    endtask

    initial begin
        logic [1:0] prev_a;
        logic       prev_v;
        int         run, starts, gaps, last_owner, n_grants;
        bit         tracking, seen;
        int         seq[$];

        rst_n   = 1'b0;
        uio_in  = 8'h00;
        req_a   = 2'b11;
        wdata_a = 16'h0000;
        woe_a   = 16'h0000;
        req_b   = 4'b0000;
        wdata_b = 32'h0;
        woe_b   = 32'h0;
        model_reset();

        // Reset held with both requests high: nothing granted, pins floated.
        repeat (3) @(posedge clk_100mhz);
        #1;
        check_all();
        chk("rst_gnt0", gnt_a, 32'd0);
        chk("rst_oe0", uio_oe_a, 32'd0);
        rst_n   = 1'b1;
        wdata_a = 16'h00A5;
        woe_a   = 16'h00FF;
        tick();
        chk("rst_gnt", gnt_a, 32'd1);
        chk("rst_grant_oe", uio_oe_a, 32'd0);
        tick();
        chk("rst_pin_oe", uio_oe_a, 32'hFF);
        chk("rst_pin_out", uio_out_a, 32'hA5);

        // Handoff 0 -> 1 with a two-cycle turnaround.
        req_a   = 2'b10;
        wdata_a = 16'h3CA5;
        woe_a   = 16'h0FFF;
        tick();
        chk("ho_oe_rel", uio_oe_a, 32'd0);
        chk("ho_gnt_rel", gnt_a, 32'd0);
        chk("ho_out_hold", uio_out_a, 32'hA5);
        tick();
        chk("ho_oe_t1", uio_oe_a, 32'd0);
        chk("ho_gnt_t1", gnt_a, 32'd0);
        tick();
        chk("ho_oe_t2", uio_oe_a, 32'd0);
        chk("ho_gnt_new", gnt_a, 32'd2);
        tick();
        chk("ho_out_new", uio_out_a, 32'h3C);
        chk("ho_oe_new", uio_oe_a, 32'h0F);

        // Preemption: both held high, owners alternate, each run 4 cycles.
        req_a = 2'b11;
        prev_a = gnt_a; run = 0; starts = 0; tracking = 0; last_owner = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (gnt_a != 2'b00 && prev_a == 2'b00) begin
                if (last_owner >= 0) chk("pre_alt", (int'(owner_a) != last_owner) ? 32'd1 : 32'd0, 32'd1);
                last_owner = int'(owner_a);
                starts++;
                run = 0;
                tracking = 1;
            end
            if (gnt_a != 2'b00) run++;
            if (gnt_a == 2'b00 && prev_a != 2'b00 && tracking) chk("pre_len", run, 32'd4);
            prev_a = gnt_a;
        end
        chk("pre_starts", (starts >= 3) ? 32'd1 : 32'd0, 32'd1);

        // Sole holder: no preemption without a competitor.
        req_a = 2'b00;
        repeat (5) tick();
        req_a = 2'b01;
        gaps = 0; seen = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (seen && gnt_a != 2'b01) gaps++;
            if (gnt_a == 2'b01) seen = 1;
        end
        chk("sole_gaps", gaps, 32'd0);
        chk("sole_gnt", gnt_a, 32'd1);
        req_a = 2'b00;
        repeat (4) tick();

        // Fairness on the 4-requester instance: each owner drops after 1 cycle.
        prev_v = owner_valid_b; n_grants = 0;
        for (int c = 0; c < 40 && n_grants < 5; c++) begin
            req_b = (m_own[1] >= 0) ? (4'hF & ~(4'b0001 << m_own[1])) : 4'hF;
            tick();
            if (owner_valid_b && !prev_v) begin
                seq.push_back(int'(owner_b));
                n_grants++;
            end
            prev_v = owner_valid_b;
        end
        chk("fair_count", n_grants, 32'd5);
        for (int k = 0; k < seq.size() && k < 5; k++) chk("fair_seq", seq[k], k % 4);
        req_b = 4'b0000;
        repeat (3) tick();

        // rdata lags uio_in by exactly two edges.
        uio_in = 8'h00;
        repeat (2) tick();
        uio_in = 8'h5A;
        tick();
        chk("rd_lag1", rdata_a, 32'h00);
        tick();
        chk("rd_lag2", rdata_a, 32'h5A);

        // Randomized traffic on both instances.
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 2; b++) if ($urandom_range(0, 3) == 0) req_a[b] = ~req_a[b];
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) req_b[b] = ~req_b[b];
            wdata_a = 16'($urandom); woe_a = 16'($urandom);
            wdata_b = $urandom;      woe_b = $urandom;
            uio_in  = 8'($urandom);
            tick();
        end

        // Asynchronous reset while owning: grant and enables drop at once.
        req_a = 2'b00; req_b = 4'b0000;
        repeat (6) tick();
        req_a = 2'b01; req_b = 4'b0100;
        woe_a = 16'hFFFF; woe_b = 32'hFFFF_FFFF;
        repeat (3) tick();
        chk("ar_pre_oe_a", uio_oe_a, 32'hFF);
        chk("ar_pre_oe_b", uio_oe_b, 32'hFF);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt_a", gnt_a, 32'd0);
        chk("ar_oe_a", uio_oe_a, 32'd0);
        chk("ar_gnt_b", gnt_b, 32'd0);
        chk("ar_oe_b", uio_oe_b, 32'd0);
        model_reset();
        @(posedge clk_100mhz);
        #1;
        rst_n = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
